mem_stage_unit: RTL and testbench

- Consumer end of the EX/M pipeline register: takes the registered EX/M fields and performs the MEM stage.
- Resolves branch/jump redirect, forwards store data from WB, and runs a req/ack handshake to a variable-latency data memory.
- Stalls the upstream pipeline while an access is pending.
- Produces the registered M/WB fields for write-back.

---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/mem_stage_unit_dmem_handshake_fsm.sv | 71 +++++++
 rtl/mem_stage_unit.sv | 114 +++++++++++
 tb/tb_mem_stage_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage: handshake state encoding,
// default memory wait budget and the store-data forwarding select values.
// No logic of its own; imported by the stage top and the handshake FSM.
package mem_stage_pkg;

  // Data memory handshake state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Cycles to wait for dmem_ack before abandoning an access
  localparam int MAX_WAIT_DEFAULT = 15;

  // Store-data source select
  localparam logic FWD_BUSB = 1'b0;
  localparam logic FWD_WB   = 1'b1;

  // Forward from WB when WB writes the non-zero register the store reads
  function automatic logic fwd_sel(input logic       wb_RegWr,
                                   input logic [4:0] wb_Rd,
                                   input logic [4:0] Rb_M);
    return (wb_RegWr && (wb_Rd != 5'd0) && (wb_Rd == Rb_M)) ? FWD_WB : FWD_BUSB;
  endfunction

endpackage

// File: rtl/mem_stage_unit_dmem_handshake_fsm.sv
// Data memory req/ack handshake: launches an access, waits for ack or timeout.
// Latency: req one edge after launch, DONE one edge after ack/timeout.
// Backpressure: variable-latency memory is absorbed by staying in BUSY.
module dmem_handshake_fsm
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        CLK,
  input  logic        Resetn,
  input  logic        access,
  input  logic        is_store,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] data_latch,
  output logic        mem_err,
  output mem_state_t  state
);

  logic [7:0] wait_cnt;

  // Handshake sequencing; acks outside BUSY fall through the case untouched
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state      <= ST_IDLE;
      wait_cnt   <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      data_latch <= 32'd0;
      mem_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= addr_in;
            dmem_wdata <= wdata_in;
            wait_cnt   <= 8'd0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) data_latch <= dmem_rdata;
            state <= ST_DONE;
          end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
            dmem_req   <= 1'b0;
            mem_err    <= 1'b1;
            data_latch <= 32'd0;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: branch redirect, WB->store forwarding, dmem access, M/WB register.
// Latency: 1 edge for non-memory ops; 3+ edges for memory ops (ack-dependent).
// Backpressure: Stall_M freezes upstream while an access is launched or pending.
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        CLK,
  input  logic        Resetn,
  input  logic        MemWr_M,
  input  logic        MemtoReg_M,
  input  logic        RegWr_M,
  input  logic        Branch_M,
  input  logic        Jump_M,
  input  logic        Zero_M,
  input  logic [31:0] ALUout_M,
  input  logic [31:0] busB_M,
  input  logic [31:0] Target_M,
  input  logic [4:0]  Rd_M,
  input  logic [4:0]  Rb_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        Stall_M,
  output logic        PCSrc,
  output logic [31:0] Target_out,
  output logic        wb_RegWr,
  output logic        wb_MemtoReg,
  output logic [4:0]  wb_Rd,
  output logic [31:0] wb_ALUout,
  output logic [31:0] wb_MemData,
  output logic        mem_err
);

  logic        access;
  logic [31:0] store_data;
  logic [31:0] data_latch;
  mem_state_t  state;

  assign access = MemWr_M | MemtoReg_M;

  // Store data comes from WB when it is about to write the register being stored
  always_comb begin
    store_data = busB_M;
    if (fwd_sel(wb_RegWr, wb_Rd, Rb_M) == FWD_WB)
      store_data = wb_MemtoReg ? wb_MemData : wb_ALUout;
  end

  // Hold upstream in the launch cycle and for every pending cycle
  always_comb begin
    Stall_M = (state == ST_BUSY) || ((state == ST_IDLE) && access);
    PCSrc   = (Jump_M | (Branch_M & Zero_M)) & ~Stall_M;
  end

  assign Target_out = Target_M;

  dmem_handshake_fsm #(
    .MAX_WAIT(MAX_WAIT)
  ) u_hs (
    .CLK       (CLK),
    .Resetn    (Resetn),
    .access    (access),
    .is_store  (MemWr_M),
    .addr_in   (ALUout_M),
    .wdata_in  (store_data),
    .dmem_rdata(dmem_rdata),
    .dmem_ack  (dmem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .data_latch(data_latch),
    .mem_err   (mem_err),
    .state     (state)
  );

  // M/WB register: bubble while the access is in flight, load when it completes
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      wb_RegWr    <= 1'b0;
      wb_MemtoReg <= 1'b0;
      wb_Rd       <= 5'd0;
      wb_ALUout   <= 32'd0;
      wb_MemData  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            wb_RegWr <= 1'b0;
          end else begin
            wb_RegWr    <= RegWr_M;
            wb_MemtoReg <= MemtoReg_M;
            wb_Rd       <= Rd_M;
            wb_ALUout   <= ALUout_M;
          end
        end
        ST_BUSY: wb_RegWr <= 1'b0;
        ST_DONE: begin
          wb_RegWr    <= RegWr_M;
          wb_MemtoReg <= MemtoReg_M;
          wb_Rd       <= Rd_M;
          wb_ALUout   <= ALUout_M;
          wb_MemData  <= data_latch;
        end
        default: wb_RegWr <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit with a short memory wait budget.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
// Memory ack/rdata are driven by hand at fixed cycles.
module tb_mem_stage_unit;

  logic        CLK = 1'b0;
  logic        Resetn;
  logic        MemWr_M, MemtoReg_M, RegWr_M, Branch_M, Jump_M, Zero_M;
  logic [31:0] ALUout_M, busB_M, Target_M;
  logic [4:0]  Rd_M, Rb_M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        Stall_M, PCSrc;
  logic [31:0] Target_out;
  logic        wb_RegWr, wb_MemtoReg;
  logic [4:0]  wb_Rd;
  logic [31:0] wb_ALUout, wb_MemData;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_stage_unit #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .Resetn(Resetn),
    .MemWr_M(MemWr_M), .MemtoReg_M(MemtoReg_M), .RegWr_M(RegWr_M),
    .Branch_M(Branch_M), .Jump_M(Jump_M), .Zero_M(Zero_M),
    .ALUout_M(ALUout_M), .busB_M(busB_M), .Target_M(Target_M),
    .Rd_M(Rd_M), .Rb_M(Rb_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .Stall_M(Stall_M), .PCSrc(PCSrc), .Target_out(Target_out),
    .wb_RegWr(wb_RegWr), .wb_MemtoReg(wb_MemtoReg), .wb_Rd(wb_Rd),
    .wb_ALUout(wb_ALUout), .wb_MemData(wb_MemData), .mem_err(mem_err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    MemWr_M = 0; MemtoReg_M = 0; RegWr_M = 0; Branch_M = 0; Jump_M = 0; Zero_M = 0;
    ALUout_M = 0; busB_M = 0; Target_M = 0; Rd_M = 0; Rb_M = 0;
    dmem_rdata = 0; dmem_ack = 0;
  endtask

  task automatic test_reset();
    Resetn = 0;
    clear_inputs();
    #12;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", dmem_req); end
    checks++; if (dmem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", dmem_addr); end
    checks++; if ({wb_RegWr, wb_MemtoReg, wb_Rd} !== 7'd0) begin errors++; $display("FAIL reset_wb_ctl got %b exp 0", {wb_RegWr, wb_MemtoReg, wb_Rd}); end
    checks++; if ({wb_ALUout, wb_MemData} !== 64'd0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", {wb_ALUout, wb_MemData}); end
    checks++; if ({mem_err, Stall_M, PCSrc} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {mem_err, Stall_M, PCSrc}); end
    step();
    Resetn = 1;
    step();
  endtask

  task automatic test_alu();
    RegWr_M = 1; Rd_M = 5'd5; ALUout_M = 32'h1234;
    #1;
    checks++; if (Stall_M !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", Stall_M); end
    step();
    checks++; if (wb_RegWr !== 1'b1 || wb_Rd !== 5'd5) begin errors++; $display("FAIL alu_wb_ctl got %b/%0d exp 1/5", wb_RegWr, wb_Rd); end
    checks++; if (wb_ALUout !== 32'h1234) begin errors++; $display("FAIL alu_wb_aluout got %h exp 1234", wb_ALUout); end
    clear_inputs();
  endtask

  task automatic test_branch();
    Branch_M = 1; Zero_M = 1; Target_M = 32'h100;
    #1;
    checks++; if (PCSrc !== 1'b1) begin errors++; $display("FAIL br_taken got %b exp 1", PCSrc); end
    checks++; if (Target_out !== 32'h100) begin errors++; $display("FAIL br_target got %h exp 100", Target_out); end
    Zero_M = 0;
    #1;
    checks++; if (PCSrc !== 1'b0) begin errors++; $display("FAIL br_not_taken got %b exp 0", PCSrc); end
    Branch_M = 0; Jump_M = 1;
    #1;
    checks++; if (PCSrc !== 1'b1) begin errors++; $display("FAIL jump got %b exp 1", PCSrc); end
    MemtoReg_M = 1;
    #1;
    checks++; if (PCSrc !== 1'b0) begin errors++; $display("FAIL jump_stalled got %b exp 0", PCSrc); end
    clear_inputs();
    #1;
  endtask

  // Load with ack in the second BUSY cycle, then a store that forwards the loaded data
  task automatic test_load();
    MemtoReg_M = 1; RegWr_M = 1; Rd_M = 5'd3; ALUout_M = 32'h40;
    #1;
    checks++; if (Stall_M !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL ld_launch stall/req got %b%b exp 10", Stall_M, dmem_req); end
    step();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h40) begin errors++; $display("FAIL ld_req1 got req=%b we=%b addr=%h exp 1 0 40", dmem_req, dmem_we, dmem_addr); end
    checks++; if (Stall_M !== 1'b1 || wb_RegWr !== 1'b0) begin errors++; $display("FAIL ld_busy1 stall/wbwr got %b%b exp 10", Stall_M, wb_RegWr); end
    step();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (dmem_req !== 1'b1 || Stall_M !== 1'b1) begin errors++; $display("FAIL ld_req2 req/stall got %b%b exp 11", dmem_req, Stall_M); end
    step();
    dmem_ack = 0; dmem_rdata = 32'h0;
    checks++; if (dmem_req !== 1'b0 || Stall_M !== 1'b0) begin errors++; $display("FAIL ld_done req/stall got %b%b exp 00", dmem_req, Stall_M); end
    step();
    checks++; if (wb_MemData !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_wb_memdata got %h exp deadbeef", wb_MemData); end
    checks++; if (wb_MemtoReg !== 1'b1 || wb_RegWr !== 1'b1 || wb_Rd !== 5'd3) begin errors++; $display("FAIL ld_wb_ctl got %b%b/%0d exp 11/3", wb_MemtoReg, wb_RegWr, wb_Rd); end
    MemtoReg_M = 0; RegWr_M = 0; Rd_M = 0;
    MemWr_M = 1; Rb_M = 5'd3; busB_M = 32'h0; ALUout_M = 32'h44;
    step();
    checks++; if (dmem_wdata !== 32'hDEADBEEF || dmem_we !== 1'b1) begin errors++; $display("FAIL st_fwd_load got wdata=%h we=%b exp deadbeef 1", dmem_wdata, dmem_we); end
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_store_fwd();
    RegWr_M = 1; Rd_M = 5'd7; ALUout_M = 32'hAA55;
    step();
    RegWr_M = 0; Rd_M = 0; MemWr_M = 1; Rb_M = 5'd7; busB_M = 32'h1111; ALUout_M = 32'h80;
    step();
    checks++; if (dmem_wdata !== 32'hAA55 || dmem_we !== 1'b1 || dmem_addr !== 32'h80) begin errors++; $display("FAIL st_fwd got wdata=%h we=%b addr=%h exp aa55 1 80", dmem_wdata, dmem_we, dmem_addr); end
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    step();
    clear_inputs();
    RegWr_M = 1; Rd_M = 5'd0; ALUout_M = 32'hAA55;
    step();
    RegWr_M = 0; MemWr_M = 1; Rb_M = 5'd0; busB_M = 32'h2222; ALUout_M = 32'h84;
    step();
    checks++; if (dmem_wdata !== 32'h2222) begin errors++; $display("FAIL st_no_fwd_r0 got %h exp 2222", dmem_wdata); end
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    MemtoReg_M = 1; RegWr_M = 1; Rd_M = 5'd9; ALUout_M = 32'h50;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dmem_req === 1'b1) req_cycles++;
    end
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL to_req_cycles got %0d exp 4", req_cycles); end
    step();
    checks++; if (dmem_req !== 1'b0 || mem_err !== 1'b1) begin errors++; $display("FAIL to_done req/err got %b%b exp 01", dmem_req, mem_err); end
    step();
    checks++; if (wb_MemData !== 32'd0 || wb_RegWr !== 1'b1) begin errors++; $display("FAIL to_wb got memdata=%h wr=%b exp 0 1", wb_MemData, wb_RegWr); end
    clear_inputs();
    step();
    step();
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", mem_err); end
  endtask

  task automatic test_reset_busy();
    MemtoReg_M = 1; RegWr_M = 1; Rd_M = 5'd2; ALUout_M = 32'h60;
    step();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_req got %b exp 1", dmem_req); end
    Resetn = 0;
    #1;
    checks++; if ({dmem_req, dmem_we, mem_err, wb_RegWr} !== 4'b0000) begin errors++; $display("FAIL rb_async got %b exp 0000", {dmem_req, dmem_we, mem_err, wb_RegWr}); end
    checks++; if ({dmem_addr, dmem_wdata} !== 64'd0) begin errors++; $display("FAIL rb_addr got %h exp 0", {dmem_addr, dmem_wdata}); end
    clear_inputs();
    step();
    Resetn = 1;
    step();
    dmem_ack = 1; dmem_rdata = 32'hFFFF0000;
    step();
    dmem_ack = 0;
    #1;
    checks++; if (dmem_req !== 1'b0 || Stall_M !== 1'b0) begin errors++; $display("FAIL rb_late_ack req/stall got %b%b exp 00", dmem_req, Stall_M); end
    RegWr_M = 1; Rd_M = 5'd4; ALUout_M = 32'h77;
    step();
    checks++; if (wb_Rd !== 5'd4 || wb_ALUout !== 32'h77 || wb_MemData !== 32'd0) begin errors++; $display("FAIL rb_idle_after got rd=%0d alu=%h md=%h exp 4 77 0", wb_Rd, wb_ALUout, wb_MemData); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_store_fwd();
    test_timeout();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
